// File: rtl/mux_2_1_pkg.sv
// Shared write-back pipeline constants: data width and SEtoReg select encoding.
package mux_2_1_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic SEL_SUM = 1'b0;
  localparam logic SEL_EXT = 1'b1;

endpackage : mux_2_1_pkg

// File: rtl/mux_2_1.sv
// Write-back result selector: combinational y plus a registered copy y_q for
// downstream pipeline and forwarding logic.
module mux_2_1
  import mux_2_1_pkg::*;
#(
  parameter int unsigned       WIDTH       = DATA_W,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  // Ternary keeps the bitwise X-merge in simulation when sel is unknown.
  assign y = (sel == SEL_EXT) ? d1 : d0;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= RESET_VALUE;
    end else begin
      y_q <= y;
    end
  end

endmodule : mux_2_1

// File: tb/tb_mux_2_1.sv
// Self-checking bench for mux_2_1: directed vectors plus a cycle-level model.
module tb_mux_2_1;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [W-1:0] y;
  logic [W-1:0] y_q;

  int n_cmp = 0;
  int n_bad = 0;

  bit           chk_on = 1'b0;
  bit           model_ok = 1'b0;
  logic [W-1:0] exp_yq;

  mux_2_1 #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .sel (sel),
    .d0  (d0),
    .d1  (d1),
    .y   (y),
    .y_q (y_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the register holds whichever input was chosen at the last edge.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      exp_yq   = 8'h00;
      model_ok = 1'b1;
    end else if (sel === 1'b1) begin
      exp_yq = d1;
    end else begin
      exp_yq = d0;
    end
  end

  // Continuous compare on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (chk_on && model_ok && !$isunknown(sel)) begin
      check("model_y", y, (sel === 1'b1) ? d1 : d0);
      check("model_y_q", y_q, exp_yq);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Basic combinational select, no edge needed between checks.
    rst = 1'b1; sel = 1'b1; d0 = 8'h10; d1 = 8'h20;
    #1;  check("basic_sel1", y, 8'h20);
    #10; sel = 1'b0;
    #1;  check("basic_sel0", y, 8'h10);

    // Reset held for two edges.
    step(); step();
    check("reset_y_q", y_q, 8'h00);
    chk_on = 1'b1;

    // Registered path.
    rst = 1'b0; sel = 1'b1; d0 = 8'h10; d1 = 8'h20;
    step(); check("reg_d1", y_q, 8'h20);
    sel = 1'b0;
    step(); check("reg_d0", y_q, 8'h10);

    // Data-only changes.
    d1 = 8'hFF;
    #1; check("unsel_change", y, 8'h10);
    d0 = 8'hA5;
    #1; check("sel_change", y, 8'hA5);
    step(); check("reg_a5", y_q, 8'hA5);

    // Reset mid-stream.
    sel = 1'b1; d1 = 8'h20;
    step(); check("pre_reset", y_q, 8'h20);
    rst = 1'b1;
    step(); check("mid_reset_y_q", y_q, 8'h00);
    check("mid_reset_y", y, 8'h20);
    rst = 1'b0;
    step(); check("post_reset", y_q, 8'h20);

    // Extremes with sel toggling every cycle.
    d0 = 8'h00; d1 = 8'hFF; sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1; check("ext_y", y, (i % 2 == 0) ? 8'h00 : 8'hFF);
      step();
      check("ext_y_q", y_q, (i % 2 == 0) ? 8'h00 : 8'hFF);
      sel = ~sel;
    end

    // Unknown select: equal input bits stay known.
    chk_on = 1'b0;
    sel = 1'bx; d0 = 8'h0F; d1 = 8'h0F;
    #1; check("x_sel_equal", y, 8'h0F);
    d0 = 8'h00; d1 = 8'h01;
    #1; check("x_sel_upper", y & 8'hFE, 8'h00);
    sel = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mux_2_1

// File: doc/mux_2_1.md
# mux_2_1

Data-width 2-to-1 selector used as the result multiplexer of the pipeline write-back stage. It chooses between the ALU sum (`d0`) and the sign-extended immediate (`d1`) under control of the `SEtoReg` decode bit, wired to `sel`. The selected value is driven combinationally on `y`, which feeds the register-file write port in the same cycle. A registered copy on `y_q` serves downstream pipeline and forwarding logic.

## Interface
- `WIDTH`, default 8: data width of `d0`, `d1`, `y` and `y_q`.
- `RESET_VALUE`, default `{WIDTH{1'b0}}`: value loaded into `y_q` on reset.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `sel`, input, 1: select. 0 picks `d0`, 1 picks `d1`.
- `d0`, input, `WIDTH`: input 0 (write-back sum).
- `d1`, input, `WIDTH`: input 1 (sign-extended immediate).
- `y`, output, `WIDTH`: combinational selected value.
- `y_q`, output, `WIDTH`: registered selected value.

## Operation
- Combinational path:
  - `y = sel ? d1 : d0`, bit-exact.
  - No arithmetic, no width conversion, no sign handling.
- Registered path:
  - Each rising `clk` with `rst`=0: `y_q` <= `y` (the value selected by `sel`, `d0`, `d1` at that edge).
  - Rising `clk` with `rst`=1: `y_q` <= `RESET_VALUE`; `y` is unaffected by reset.
- `sel` unknown (X/Z):
  - Synthesis: behaves as a plain 2:1 mux.
  - Simulation: `y` must resolve bitwise, so bits where `d0`==`d1` are known and differing bits are X.
- No enable, no handshake, no internal state besides the `y_q` register.

## Timing
- `y`: zero-cycle latency; purely combinational from `sel`, `d0` and `d1`. It must not depend on `clk` or `rst`.
- `y_q`: one-cycle latency after the sampling edge.
- Reset value:
  - `y_q` = `RESET_VALUE` from the first edge with `rst`=1.
  - It holds that value for every edge while `rst` stays high.
- Reset released mid-stream: the first edge with `rst`=0 captures the current selection. No extra bubble.
- Simultaneous change of `sel` and data: `y` reflects the new combination immediately, and `y_q` captures it at the next edge.
- No combinational path from `y_q` back into any input.

## Structure
- Shared pipeline package: `DATA_W` = 8 (default for `WIDTH`), plus the `SEtoReg` select encoding constants `SEL_SUM` = 0 and `SEL_EXT` = 1.
- Single module, no sub-modules. The output flop is inline; a generic flop wrapper is not warranted.

## Test plan
- Basic select: `sel`=1, `d0`=0x10, `d1`=0x20 gives `y`=0x20. After 10 time units, `sel`=0 gives `y`=0x10 with no clock edge required.
- Registered path: `rst`=1 for 2 edges gives `y_q`=0x00. Release `rst`, drive `sel`=1, `d0`=0x10, `d1`=0x20. After one edge `y_q`=0x20; set `sel`=0 and after the next edge `y_q`=0x10.
- Data-only change: hold `sel`=0 and change `d1` 0x20→0xFF. `y` stays 0x10. Then change `d0` to 0xA5 and `y`=0xA5 immediately.
- Reset mid-stream: `y_q`=0x20. Assert `rst` for one edge and `y_q`=0x00 while `y` still equals the selected input. Deassert, and the next edge restores the selected value.
- Extremes: `d0`=0x00, `d1`=0xFF with `sel` toggling every cycle. `y` alternates 0x00/0xFF, and `y_q` follows one cycle later.
- X select (simulation): `sel`=X, `d0`=0x0F, `d1`=0x0F gives `y`=0x0F. With `d0`=0x00, `d1`=0x01, `y` = 0000000X.
